// File: rtl/dma_read_scheduler.sv
// dma_read_scheduler: round-robin sharing of one AXI3 DMA reader between NumReq requesters.
// Define DMA_SCHED_STATS_EN to add saturating per-requester done/error counters.
module dma_read_scheduler #(
  parameter int NumReq     = 4,
  parameter int AddrBits   = 32,
  parameter int LengthBits = 16,
  parameter int BurstBits  = 5,
  parameter int IdBits     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef DMA_SCHED_STATS_EN
  input  logic [IdBits-1:0]            stat_sel,
  output logic [31:0]                  stat_count,
  output logic [15:0]                  stat_err,
`endif
  input  logic [NumReq-1:0]            req_valid,
  input  logic [NumReq*AddrBits-1:0]   req_source,
  input  logic [NumReq*LengthBits-1:0] req_len,
  input  logic [BurstBits-1:0]         req_burst,
  output logic [NumReq-1:0]            req_ack,
  output logic [NumReq-1:0]            req_done,
  output logic [1:0]                   req_err,
  output logic                         grant_valid,
  output logic [IdBits-1:0]            grant_id,
  output logic [AddrBits-1:0]          cfg_source,
  output logic [LengthBits-1:0]        cfg_len,
  output logic [BurstBits-1:0]         cfg_burst,
  output logic                         cfg_valid,
  input  logic                         cfg_busy,
  input  logic                         cfg_done,
  input  logic [1:0]                   cfg_err
);
  typedef enum logic [1:0] {ARB, ISSUE, RUN, RELEASE} state_t;
  state_t state, state_n;
  logic [IdBits-1:0] rr_ptr, pick;
  function automatic logic [IdBits-1:0] wrap(input int v);
    return IdBits'(v >= NumReq ? v - NumReq : v);
  endfunction
  // Descending scan so the requester closest to rr_ptr wins.
  always_comb begin
    pick = '0;
    for (int k = NumReq - 1; k >= 0; k--)
      if (req_valid[wrap(int'(rr_ptr) + k)]) pick = wrap(int'(rr_ptr) + k);
  end
  always_comb begin
    state_n = state == ARB   ? ((|req_valid && !cfg_busy) ? ISSUE : ARB) :
              state == ISSUE ? RUN :
              state == RUN   ? (cfg_done ? RELEASE : RUN) :
                               (cfg_busy ? RELEASE : ARB);
    cfg_valid   = state == ISSUE;
    grant_valid = state != ARB;
    req_ack     = cfg_valid ? NumReq'(1) << grant_id : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      grant_id   <= '0;
      cfg_source <= '0;
      cfg_len    <= '0;
      cfg_burst  <= '0;
      req_done   <= '0;
      req_err    <= '0;
    end else begin
      state    <= state_n;
      req_done <= '0;
      req_err  <= '0;
      if (state == ARB && state_n == ISSUE) begin
        grant_id   <= pick;
        cfg_source <= req_source[pick*AddrBits +: AddrBits];
        cfg_len    <= req_len[pick*LengthBits +: LengthBits];
        cfg_burst  <= req_burst;
      end
      if (state == RUN && cfg_done) begin
        req_done <= NumReq'(1) << grant_id;
        req_err  <= cfg_err;
        rr_ptr   <= wrap(int'(grant_id) + 1);
      end
    end
  end
`ifdef DMA_SCHED_STATS_EN
  logic [31:0] cnt  [NumReq];
  logic [15:0] errs [NumReq];
  always_ff @(posedge clk)
    for (int i = 0; i < NumReq; i++)
      if (rst) begin
        cnt[i]  <= '0;
        errs[i] <= '0;
      end else if (req_done[i]) begin
        cnt[i]  <= cnt[i] + {31'b0, ~&cnt[i]};
        errs[i] <= errs[i] + {15'b0, |req_err && ~&errs[i]};
      end
  assign stat_count = cnt[stat_sel];
  assign stat_err   = errs[stat_sel];
`endif
endmodule
